// File: rtl/tx_burst_scheduler.sv
// tx_burst_scheduler
//
// Sequences the BPSK transmit modulator for ranging pings. A trigger in IDLE
// latches the burst configuration and the first sequence index, then each ping
// runs LOAD (ROM settle) -> START (one-cycle start pulse) -> TX (transmission
// timing) -> GUARD (programmable gap). After each ping the burst either ends
// with an odone pulse or loops back to LOAD, optionally hopping the index.
//
// Ports:
//   ctx_clk        clock
//   rtx_rst        synchronous active-high reset
//   ienable        block enable; low aborts the burst and idles
//   itrigger       start-burst request, sampled only in IDLE
//   istop          end the burst after the current ping
//   isequence_id   first sequence index of the burst (sampled in IDLE)
//   ihop_en        advance the index by one after every ping
//   iburst_len     pings per burst, 0 = continuous
//   iguard         idle cycles between pings
//   osequence_sel  sequence-bank select
//   omod_enable    modulator enable, high whenever busy
//   omod_start     one-cycle modulator start pulse
//   obusy          high in any state other than IDLE
//   oping          one-cycle pulse at the start of each ping
//   odone          one-cycle pulse when a burst completes normally
//   oping_count    pings started in the current burst (wraps)

module tx_burst_scheduler #(
  parameter int unsigned NOS       = 64,
  parameter int unsigned IDW       = 6,
  parameter int unsigned TX_CYCLES = 40962,
  parameter int unsigned TXW       = 16,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic           ctx_clk,
  input  logic           rtx_rst,
  input  logic           ienable,
  input  logic           itrigger,
  input  logic           istop,
  input  logic [IDW-1:0] isequence_id,
  input  logic           ihop_en,
  input  logic [7:0]     iburst_len,
  input  logic [15:0]    iguard,
  output logic [IDW-1:0] osequence_sel,
  output logic           omod_enable,
  output logic           omod_start,
  output logic           obusy,
  output logic           oping,
  output logic           odone,
  output logic [7:0]     oping_count
);

  // One shared cycle counter serves LOAD, TX and GUARD; it must hold both the
  // transmit terminal count and the widest guard value.
  localparam int unsigned CW = (TXW > 16) ? TXW : 16;

  localparam logic [CW-1:0] LoadLast = CW'(ROM_LAT - 1);
  localparam logic [CW-1:0] TxLast   = CW'(TX_CYCLES - 1);
  localparam logic [IDW-1:0] SelMax  = IDW'(NOS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StTx,
    StGuard
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]  cnt_q;
  logic [7:0]     len_q;
  logic           hop_q;
  logic [15:0]    guard_q;
  logic           stop_q;
  logic [IDW-1:0] sel_q;
  logic [7:0]     count_q;

  logic          tx_last;
  logic          guard_last;
  logic          ping_end;
  logic          burst_end;
  logic [CW-1:0] guard_last_cnt;

  // Terminal counts and the end-of-ping decision.
  always_comb begin
    guard_last_cnt = CW'(guard_q) - CW'(1);
    tx_last        = (state_q == StTx) && (cnt_q == TxLast);
    guard_last     = (state_q == StGuard) && (cnt_q == guard_last_cnt);
    // A zero guard skips GUARD entirely, so the decision is taken at TX end.
    ping_end       = (tx_last && (guard_q == 16'd0)) || guard_last;
    // A stop arriving on the decision cycle itself still ends the burst.
    burst_end      = ping_end &&
                     (((len_q != 8'd0) && (count_q == len_q)) || stop_q || istop);
  end

  // State register.
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!ienable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (itrigger) state_d = StLoad;
        end
        StLoad: begin
          if (cnt_q == LoadLast) state_d = StStart;
        end
        StStart: begin
          state_d = StTx;
        end
        StTx: begin
          if (tx_last) begin
            if (guard_q != 16'd0) begin
              state_d = StGuard;
            end else begin
              state_d = burst_end ? StIdle : StLoad;
            end
          end
        end
        StGuard: begin
          if (guard_last) state_d = burst_end ? StIdle : StLoad;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath: counters, latched burst configuration, index and ping count.
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      cnt_q   <= '0;
      len_q   <= '0;
      hop_q   <= 1'b0;
      guard_q <= '0;
      stop_q  <= 1'b0;
      sel_q   <= '0;
      count_q <= '0;
    end else if (!ienable) begin
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      count_q <= '0;
    end else begin
      // Counter restarts on every state change so each phase counts from 0.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q inside {StLoad, StTx, StGuard}) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (state_q == StIdle) begin
        if (itrigger) begin
          len_q   <= iburst_len;
          hop_q   <= ihop_en;
          guard_q <= iguard;
          sel_q   <= isequence_id;
          count_q <= '0;
          // Trigger and stop together: burst starts but only one ping goes out.
          stop_q  <= istop;
        end else begin
          stop_q  <= 1'b0;
        end
      end else if (istop) begin
        stop_q <= 1'b1;
      end

      if (state_q == StStart) begin
        count_q <= count_q + 8'd1;
      end

      if (ping_end && !burst_end && hop_q) begin
        sel_q <= (sel_q == SelMax) ? '0 : sel_q + IDW'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    obusy         = (state_q != StIdle);
    omod_enable   = (state_q != StIdle);
    omod_start    = (state_q == StStart);
    oping         = (state_q == StStart);
    // An abort via ienable never reports a completed burst.
    odone         = ienable && burst_end;
    osequence_sel = sel_q;
    oping_count   = count_q;
  end

endmodule

// File: tb/tb_tx_burst_scheduler.sv
module tb_tx_burst_scheduler;

  localparam int NOS = 64;
  localparam int IDW = 6;
  localparam int TXC = 20;
  localparam int TXW = 16;
  localparam int RL  = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           trig;
  logic           stop;
  logic [IDW-1:0] sid;
  logic           hop;
  logic [7:0]     blen;
  logic [15:0]    guard;
  logic [IDW-1:0] sel;
  logic           men;
  logic           mstart;
  logic           busy;
  logic           ping;
  logic           done;
  logic [7:0]     pcnt;

  tx_burst_scheduler #(
    .NOS       (NOS),
    .IDW       (IDW),
    .TX_CYCLES (TXC),
    .TXW       (TXW),
    .ROM_LAT   (RL)
  ) dut (
    .ctx_clk       (clk),
    .rtx_rst       (rst),
    .ienable       (en),
    .itrigger      (trig),
    .istop         (stop),
    .isequence_id  (sid),
    .ihop_en       (hop),
    .iburst_len    (blen),
    .iguard        (guard),
    .osequence_sel (sel),
    .omod_enable   (men),
    .omod_start    (mstart),
    .obusy         (busy),
    .oping         (ping),
    .odone         (done),
    .oping_count   (pcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit is_done;
    int cycle;
    int sel;
    int cnt;
  } ev_t;

  ev_t expq[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit is_done, input int c, input int s, input int n);
    ev_t e;
    e.is_done = is_done;
    e.cycle   = c;
    e.sel     = s % NOS;
    e.cnt     = n % 256;
    expq.push_back(e);
  endtask

  // Expected events of a burst: n pings spaced p apart from s0, then odone.
  task automatic push_burst(input int id, input bit h, input int s0, input int p,
                            input int n, input int g, input bit with_done);
    for (int k = 0; k < n; k++) push_ev(1'b0, s0 + k * p, id + (h ? k : 0), k);
    if (with_done) push_ev(1'b1, s0 + (n - 1) * p + TXC + g, id + (h ? n - 1 : 0), n);
  endtask

  // Monitor: compare every start pulse and odone against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mstart || ping) check("oping_vs_start", int'(ping), int'(mstart));
      if (mstart) begin
        if (expq.size() == 0 || expq[0].is_done) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: got start expected none (cycle %0d)", cyc);
        end else begin
          ev_t e;
          e = expq.pop_front();
          check("start_cycle", cyc, e.cycle);
          check("start_sel", int'(sel), e.sel);
          check("start_count", int'(pcnt), e.cnt);
        end
      end
      if (done) begin
        if (expq.size() == 0 || !expq[0].is_done) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got odone expected none (cycle %0d)", cyc);
        end else begin
          ev_t e;
          e = expq.pop_front();
          check("done_cycle", cyc, e.cycle);
          check("done_sel", int'(sel), e.sel);
          check("done_count", int'(pcnt), e.cnt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_men"}, int'(men), 0);
    check({tag, "_start"}, int'(mstart), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ping"}, int'(ping), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_sel"}, int'(sel), 0);
    check({tag, "_count"}, int'(pcnt), 0);
  endtask

  // Full burst from IDLE. stop_ping>0 pulses istop inside that ping's TX window.
  task automatic run_burst(input int id, input bit h, input int len, input int g,
                           input int stop_ping, input bit stop_same);
    int c, s0, p, n;
    sid   = IDW'(id);
    hop   = h;
    blen  = 8'(len);
    guard = 16'(g);
    trig  = 1'b1;
    stop  = stop_same;
    c     = cyc;
    step();
    trig  = 1'b0;
    stop  = 1'b0;
    p  = TXC + g + RL + 1;
    s0 = c + 1 + RL;
    if (stop_same) n = 1;
    else if (stop_ping > 0) n = (len == 0 || stop_ping < len) ? stop_ping : len;
    else n = len;
    push_burst(id, h, s0, p, n, g, 1'b1);
    if (!stop_same && stop_ping > 0) begin
      wait_until(s0 + (stop_ping - 1) * p + $urandom_range(1, TXC));
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
    wait_until(s0 + (n - 1) * p + TXC + g + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c, s0, s1, d1, d2, p;
    rst = 1'b1; en = 1'b1; trig = 1'b0; stop = 1'b0;
    sid = '0; hop = 1'b0; blen = '0; guard = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Fixed-index burst of three pings with a guard gap.
    run_burst(10, 1'b0, 3, 5, 0, 1'b0);
    check("burst3_final_count", int'(pcnt), 3);
    check("burst3_idle_busy", int'(busy), 0);

    // Hopping from the top index wraps to 0.
    run_burst(63, 1'b1, 3, 5, 0, 1'b0);

    // Continuous, zero guard, stop during the 4th ping.
    run_burst(3, 1'b0, 0, 0, 4, 1'b0);

    // Disable in the middle of ping 2's transmission.
    sid = 6'd5; hop = 1'b1; blen = 8'd3; guard = 16'd3; trig = 1'b1;
    c = cyc;
    step();
    trig = 1'b0;
    p  = TXC + 3 + RL + 1;
    s0 = c + 1 + RL;
    push_burst(5, 1'b1, s0, p, 2, 3, 1'b0);
    wait_until(s0 + p + 7);
    en = 1'b0;
    step();
    en = 1'b1;
    check("abort_men", int'(men), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_count", int'(pcnt), 0);
    repeat (5) step();
    run_burst(7, 1'b0, 1, 0, 0, 1'b0);

    // Trigger held high through a one-ping burst re-arms right after IDLE.
    sid = 6'd20; hop = 1'b0; blen = 8'd1; guard = 16'd2; trig = 1'b1;
    c = cyc;
    step();
    s0 = c + 1 + RL;
    d1 = s0 + TXC + 2;
    s1 = d1 + 2 + RL;
    d2 = s1 + TXC + 2;
    push_burst(20, 1'b0, s0, TXC + 2 + RL + 1, 1, 2, 1'b1);
    push_burst(20, 1'b0, s1, TXC + 2 + RL + 1, 1, 2, 1'b1);
    wait_until(d1 + 3);
    trig = 1'b0;
    wait_until(d2 + 2);

    // Reset while in GUARD.
    sid = 6'd33; hop = 1'b0; blen = 8'd2; guard = 16'd6; trig = 1'b1;
    c = cyc;
    step();
    trig = 1'b0;
    s0 = c + 1 + RL;
    push_ev(1'b0, s0, 33, 0);
    wait_until(s0 + TXC + 3);
    rst = 1'b1;
    step();
    check_all_zero("guard_reset");
    rst = 1'b0;
    step();

    // Trigger and stop in the same IDLE cycle: exactly one ping.
    run_burst(12, 1'b1, 3, 2, 0, 1'b1);

    // Randomized bursts.
    for (int i = 0; i < 8; i++) begin
      int id, len, g, sp;
      bit h;
      id  = int'($urandom_range(0, NOS - 1));
      h   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(0, 4));
      g   = int'($urandom_range(0, 6));
      sp  = (len == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, len));
      run_burst(id, h, len, g, sp, 1'b0);
      repeat (int'($urandom_range(0, 3))) step();
    end

    step();
    check("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
